cps2_out_timing_gen: RTL and testbench

Output-side video timing generator for the CPS2 digital AV path, clocked by PCLK_out. It produces the raster counters, line-buffer read address, pixel/line replication counters, syncs, DE and border mask consumed by the scanconverter stage. It frame-locks the output raster to the source VSYNC so the 40-line buffer read pointer trails the write pointer by a fixed distance.

---
 rtl/cps2_out_timing_gen.sv | 205 ++++++++++++++++++++
 tb/tb_cps2_out_timing_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cps2_out_timing_gen.sv
// cps2_out_timing_gen: output raster generator for the CPS2 AV path.
// Produces the raster counters, line-buffer read coordinates, replication
// counters, registered syncs/DE/border mask, and frame-locks the output
// raster to the source VSYNC.
module cps2_out_timing_gen #(
  parameter int unsigned H_TOTAL     = 1650,
  parameter int unsigned H_SYNCLEN   = 40,
  parameter int unsigned H_BACKPORCH = 220,
  parameter int unsigned H_ACTIVE    = 1280,
  parameter int unsigned V_TOTAL     = 750,
  parameter int unsigned V_SYNCLEN   = 5,
  parameter int unsigned V_BACKPORCH = 20,
  parameter int unsigned V_ACTIVE    = 720,
  parameter int unsigned H_MULT      = 3,
  parameter int unsigned V_MULT      = 3,
  parameter int unsigned V_LOCK_LINE = 10
) (
  input  logic        PCLK_out,
  input  logic        reset_n,
  input  logic        VSYNC_in,
  input  logic        lock_en,
  output logic [10:0] hcnt_ext,
  output logic [10:0] vcnt_ext,
  output logic [8:0]  hcnt_ext_lbuf,
  output logic [5:0]  vcnt_ext_lbuf,
  output logic [2:0]  hctr_ext,
  output logic [2:0]  vctr_ext,
  output logic        HSYNC_ext,
  output logic        VSYNC_ext,
  output logic        DE_ext,
  output logic        mask_enable_ext,
  output logic        locked
);

  localparam int unsigned SRC_H = 384;
  localparam int unsigned SRC_V = 224;
  localparam int unsigned NB    = 40;

  localparam int unsigned HA = H_SYNCLEN + H_BACKPORCH;
  localparam int unsigned VA = V_SYNCLEN + V_BACKPORCH;
  localparam int unsigned HI = HA + (H_ACTIVE - SRC_H * H_MULT) / 2;
  localparam int unsigned VI = VA + (V_ACTIVE - SRC_V * V_MULT) / 2;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] HSL     = 11'(H_SYNCLEN);
  localparam logic [10:0] VSL     = 11'(V_SYNCLEN);
  localparam logic [10:0] HA_L    = 11'(HA);
  localparam logic [10:0] HAE_L   = 11'(HA + H_ACTIVE);
  localparam logic [10:0] VA_L    = 11'(VA);
  localparam logic [10:0] VAE_L   = 11'(VA + V_ACTIVE);
  localparam logic [10:0] HI_L    = 11'(HI);
  localparam logic [10:0] HIE_L   = 11'(HI + SRC_H * H_MULT);
  localparam logic [10:0] VI_L    = 11'(VI);
  localparam logic [10:0] VIE_L   = 11'(VI + SRC_V * V_MULT);
  localparam logic [10:0] VLOCK_L = 11'(V_LOCK_LINE);
  localparam logic [2:0]  HM_LAST = 3'(H_MULT - 1);
  localparam logic [2:0]  VM_LAST = 3'(V_MULT - 1);
  localparam logic [5:0]  NB_LAST = 6'(NB - 1);

  logic        line_step;
  logic [10:0] hcnt_nxt;
  logic [10:0] vcnt_nat;
  logic [10:0] vcnt_nxt;
  logic        h_img_nxt;
  logic        v_img_nxt;
  logic [2:0]  hctr_nxt;
  logic [8:0]  hlbuf_nxt;
  logic [2:0]  vctr_nxt;
  logic [5:0]  vlbuf_nxt;
  logic        h_act;
  logic        v_act;
  logic        h_img;
  logic        v_img;
  logic        vs_sync1;
  logic        vs_sync2;
  logic        vs_hist;
  logic        vs_fall;
  logic        pending;

  // Next-state of the raster and replication counters; the replication
  // counters are computed from the next raster position so that they are
  // aligned with the registered hcnt/vcnt of the same cycle.
  always_comb begin
    line_step = (hcnt_ext == H_LAST);
    hcnt_nxt  = line_step ? '0 : hcnt_ext + 11'd1;
    vcnt_nat  = (vcnt_ext == V_LAST) ? '0 : vcnt_ext + 11'd1;
    vcnt_nxt  = vcnt_ext;
    if (line_step) begin
      vcnt_nxt = pending ? VLOCK_L : vcnt_nat;
    end

    h_img_nxt = (hcnt_nxt >= HI_L) && (hcnt_nxt < HIE_L);
    v_img_nxt = (vcnt_nxt >= VI_L) && (vcnt_nxt < VIE_L);

    hctr_nxt  = '0;
    hlbuf_nxt = '0;
    if (hcnt_nxt == HI_L) begin
      hctr_nxt  = '0;
      hlbuf_nxt = '0;
    end else if (h_img_nxt) begin
      if (hctr_ext == HM_LAST) begin
        hctr_nxt  = '0;
        hlbuf_nxt = hcnt_ext_lbuf + 9'd1;
      end else begin
        hctr_nxt  = hctr_ext + 3'd1;
        hlbuf_nxt = hcnt_ext_lbuf;
      end
    end

    vctr_nxt  = vctr_ext;
    vlbuf_nxt = vcnt_ext_lbuf;
    if (line_step) begin
      if (vcnt_nxt == VI_L) begin
        vctr_nxt  = '0;
        vlbuf_nxt = '0;
      end else if (v_img_nxt) begin
        if (vctr_ext == VM_LAST) begin
          vctr_nxt  = '0;
          vlbuf_nxt = (vcnt_ext_lbuf == NB_LAST) ? '0 : vcnt_ext_lbuf + 6'd1;
        end else begin
          vctr_nxt  = vctr_ext + 3'd1;
        end
      end else begin
        vctr_nxt  = '0;
        vlbuf_nxt = '0;
      end
    end

    h_act   = (hcnt_ext >= HA_L) && (hcnt_ext < HAE_L);
    v_act   = (vcnt_ext >= VA_L) && (vcnt_ext < VAE_L);
    h_img   = (hcnt_ext >= HI_L) && (hcnt_ext < HIE_L);
    v_img   = (vcnt_ext >= VI_L) && (vcnt_ext < VIE_L);
    vs_fall = vs_hist & ~vs_sync2;
  end

  // Raster and replication counter registers.
  always_ff @(posedge PCLK_out or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_ext      <= '0;
      vcnt_ext      <= '0;
      hctr_ext      <= '0;
      vctr_ext      <= '0;
      hcnt_ext_lbuf <= '0;
      vcnt_ext_lbuf <= '0;
    end else begin
      hcnt_ext      <= hcnt_nxt;
      vcnt_ext      <= vcnt_nxt;
      hctr_ext      <= hctr_nxt;
      vctr_ext      <= vctr_nxt;
      hcnt_ext_lbuf <= hlbuf_nxt;
      vcnt_ext_lbuf <= vlbuf_nxt;
    end
  end

  // Syncs, DE and border mask lag the counters by one clock.
  always_ff @(posedge PCLK_out or negedge reset_n) begin
    if (!reset_n) begin
      HSYNC_ext       <= 1'b1;
      VSYNC_ext       <= 1'b1;
      DE_ext          <= 1'b0;
      mask_enable_ext <= 1'b0;
    end else begin
      HSYNC_ext       <= !(hcnt_ext < HSL);
      VSYNC_ext       <= !(vcnt_ext < VSL);
      DE_ext          <= h_act && v_act;
      mask_enable_ext <= h_act && v_act && !(h_img && v_img);
    end
  end

  // Source VSYNC synchroniser plus history stage for edge detection.
  always_ff @(posedge PCLK_out or negedge reset_n) begin
    if (!reset_n) begin
      vs_sync1 <= 1'b1;
      vs_sync2 <= 1'b1;
      vs_hist  <= 1'b1;
    end else begin
      vs_sync1 <= VSYNC_in;
      vs_sync2 <= vs_sync1;
      vs_hist  <= vs_sync2;
    end
  end

  // Lock request and status; an edge arriving on the line step itself is
  // carried into the next line instead of being lost when pending clears.
  always_ff @(posedge PCLK_out or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      locked  <= 1'b0;
    end else if (!lock_en) begin
      pending <= 1'b0;
      locked  <= 1'b0;
    end else begin
      if (line_step) begin
        pending <= vs_fall;
        if (pending) begin
          locked <= (vcnt_nat == VLOCK_L);
        end
      end else if (vs_fall) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cps2_out_timing_gen.sv
// Directed bench for cps2_out_timing_gen using a reduced raster so that the
// vertical replication wrap and lock scenarios fit in a short run.
// Raster: H 784 (sync 4, bp 4, active 772), V 458 (sync 2, bp 2, active 452),
// H_MULT 2, V_MULT 2, V_LOCK_LINE 3 -> HA 8, HI 10, image cols [10,778),
// DE cols [8,780), VA 4, VI 6.
module tb_cps2_out_timing_gen;

  localparam int H_TOT = 784;
  localparam int LIMIT = 784 * 100;

  logic        PCLK_out;
  logic        reset_n;
  logic        VSYNC_in;
  logic        lock_en;
  logic [10:0] hcnt_ext;
  logic [10:0] vcnt_ext;
  logic [8:0]  hcnt_ext_lbuf;
  logic [5:0]  vcnt_ext_lbuf;
  logic [2:0]  hctr_ext;
  logic [2:0]  vctr_ext;
  logic        HSYNC_ext;
  logic        VSYNC_ext;
  logic        DE_ext;
  logic        mask_enable_ext;
  logic        locked;

  int total;
  int bad;

  cps2_out_timing_gen #(
    .H_TOTAL(784), .H_SYNCLEN(4), .H_BACKPORCH(4), .H_ACTIVE(772),
    .V_TOTAL(458), .V_SYNCLEN(2), .V_BACKPORCH(2), .V_ACTIVE(452),
    .H_MULT(2), .V_MULT(2), .V_LOCK_LINE(3)
  ) dut (
    .PCLK_out(PCLK_out), .reset_n(reset_n), .VSYNC_in(VSYNC_in), .lock_en(lock_en),
    .hcnt_ext(hcnt_ext), .vcnt_ext(vcnt_ext),
    .hcnt_ext_lbuf(hcnt_ext_lbuf), .vcnt_ext_lbuf(vcnt_ext_lbuf),
    .hctr_ext(hctr_ext), .vctr_ext(vctr_ext),
    .HSYNC_ext(HSYNC_ext), .VSYNC_ext(VSYNC_ext), .DE_ext(DE_ext),
    .mask_enable_ext(mask_enable_ext), .locked(locked)
  );

  initial PCLK_out = 1'b0;
  always #5 PCLK_out = ~PCLK_out;

  task automatic tick();
    @(posedge PCLK_out);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance to a raster position, bounded by LIMIT clocks.
  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    while (!(hcnt_ext == 11'(h) && vcnt_ext == 11'(v)) && n < LIMIT) begin
      tick();
      n++;
    end
    total++;
    if (hcnt_ext !== 11'(h) || vcnt_ext !== 11'(v)) begin
      bad++;
      $display("FAIL wait_pos got=%0d/%0d want=%0d/%0d", hcnt_ext, vcnt_ext, h, v);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    VSYNC_in = 1'b1;
    lock_en  = 1'b1;
    ticks(3);
    total++; if (hcnt_ext !== 11'd0) begin bad++; $display("FAIL rst_hcnt got=%0d want=0", hcnt_ext); end
    total++; if (vcnt_ext !== 11'd0) begin bad++; $display("FAIL rst_vcnt got=%0d want=0", vcnt_ext); end
    total++; if (hcnt_ext_lbuf !== 9'd0 || vcnt_ext_lbuf !== 6'd0) begin bad++; $display("FAIL rst_lbuf got=%0d/%0d want=0/0", hcnt_ext_lbuf, vcnt_ext_lbuf); end
    total++; if (hctr_ext !== 3'd0 || vctr_ext !== 3'd0) begin bad++; $display("FAIL rst_ctr got=%0d/%0d want=0/0", hctr_ext, vctr_ext); end
    total++; if (HSYNC_ext !== 1'b1 || VSYNC_ext !== 1'b1) begin bad++; $display("FAIL rst_sync got=%b%b want=11", HSYNC_ext, VSYNC_ext); end
    total++; if (DE_ext !== 1'b0 || mask_enable_ext !== 1'b0 || locked !== 1'b0) begin bad++; $display("FAIL rst_de_mask_lock got=%b%b%b want=000", DE_ext, mask_enable_ext, locked); end
    reset_n = 1'b1;
    tick();
    total++; if (hcnt_ext !== 11'd1 || vcnt_ext !== 11'd0) begin bad++; $display("FAIL first_clk got=%0d/%0d want=1/0", hcnt_ext, vcnt_ext); end
    total++; if (VSYNC_ext !== 1'b0 || DE_ext !== 1'b0) begin bad++; $display("FAIL first_vs_de got=%b%b want=00", VSYNC_ext, DE_ext); end
    // Clock k shows HSYNC for hcnt=k-1: low for k=1..4, high from k=5.
    for (int k = 1; k <= 6; k++) begin
      total++;
      if (HSYNC_ext !== ((k <= 4) ? 1'b0 : 1'b1)) begin
        bad++; $display("FAIL hsync_clk%0d got=%b want=%b", k, HSYNC_ext, (k <= 4) ? 1'b0 : 1'b1);
      end
      if (k < 6) tick();
    end
  endtask

  // Two edges inside line 2: one jump to 3, natural value also 3 -> locked.
  task automatic test_lock_double();
    wait_pos(5, 2);
    total++; if (VSYNC_ext !== 1'b1) begin bad++; $display("FAIL vsync_line2 got=%b want=1", VSYNC_ext); end
    VSYNC_in = 1'b0; ticks(8);
    VSYNC_in = 1'b1; ticks(8);
    VSYNC_in = 1'b0; ticks(8);
    VSYNC_in = 1'b1;
    wait_pos(H_TOT - 1, 2);
    tick();
    total++; if (vcnt_ext !== 11'd3 || hcnt_ext !== 11'd0) begin bad++; $display("FAIL dbl_jump got=%0d/%0d want=3/0", vcnt_ext, hcnt_ext); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL dbl_locked got=%b want=1", locked); end
    wait_pos(20, 3);
    total++; if (DE_ext !== 1'b0) begin bad++; $display("FAIL de_line3 got=%b want=0", DE_ext); end
    wait_pos(H_TOT - 1, 3);
    tick();
    total++; if (vcnt_ext !== 11'd4 || locked !== 1'b1) begin bad++; $display("FAIL dbl_single got=%0d/%b want=4/1", vcnt_ext, locked); end
  endtask

  task automatic test_lock_disable();
    lock_en = 1'b0;
    tick();
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL dis_locked got=%b want=0", locked); end
    wait_pos(20, 4);
    total++; if (DE_ext !== 1'b1 || mask_enable_ext !== 1'b1) begin bad++; $display("FAIL vborder got=%b%b want=11", DE_ext, mask_enable_ext); end
    VSYNC_in = 1'b0; ticks(8);
    VSYNC_in = 1'b1;
    wait_pos(H_TOT - 1, 4);
    tick();
    total++; if (vcnt_ext !== 11'd5 || locked !== 1'b0) begin bad++; $display("FAIL dis_nojump got=%0d/%b want=5/0", vcnt_ext, locked); end
    lock_en = 1'b1;
  endtask

  task automatic test_hrep();
    wait_pos(8, 6);
    total++; if (DE_ext !== 1'b0 || mask_enable_ext !== 1'b0) begin bad++; $display("FAIL h8 got=%b%b want=00", DE_ext, mask_enable_ext); end
    wait_pos(9, 6);
    total++; if (DE_ext !== 1'b1 || mask_enable_ext !== 1'b1 || hctr_ext !== 3'd0) begin bad++; $display("FAIL h9 got=%b%b/%0d want=11/0", DE_ext, mask_enable_ext, hctr_ext); end
    wait_pos(10, 6);
    total++; if (hctr_ext !== 3'd0 || hcnt_ext_lbuf !== 9'd0 || vctr_ext !== 3'd0 || vcnt_ext_lbuf !== 6'd0) begin bad++; $display("FAIL h10 got=%0d/%0d/%0d/%0d want=0/0/0/0", hctr_ext, hcnt_ext_lbuf, vctr_ext, vcnt_ext_lbuf); end
    total++; if (mask_enable_ext !== 1'b1) begin bad++; $display("FAIL h10_mask got=%b want=1", mask_enable_ext); end
    wait_pos(11, 6);
    total++; if (hctr_ext !== 3'd1 || hcnt_ext_lbuf !== 9'd0 || DE_ext !== 1'b1 || mask_enable_ext !== 1'b0) begin bad++; $display("FAIL h11 got=%0d/%0d/%b%b want=1/0/10", hctr_ext, hcnt_ext_lbuf, DE_ext, mask_enable_ext); end
    wait_pos(12, 6);
    total++; if (hctr_ext !== 3'd0 || hcnt_ext_lbuf !== 9'd1) begin bad++; $display("FAIL h12 got=%0d/%0d want=0/1", hctr_ext, hcnt_ext_lbuf); end
    wait_pos(777, 6);
    total++; if (hctr_ext !== 3'd1 || hcnt_ext_lbuf !== 9'd383 || mask_enable_ext !== 1'b0) begin bad++; $display("FAIL h777 got=%0d/%0d/%b want=1/383/0", hctr_ext, hcnt_ext_lbuf, mask_enable_ext); end
    wait_pos(778, 6);
    total++; if (hctr_ext !== 3'd0 || hcnt_ext_lbuf !== 9'd0) begin bad++; $display("FAIL h778 got=%0d/%0d want=0/0", hctr_ext, hcnt_ext_lbuf); end
    wait_pos(779, 6);
    total++; if (DE_ext !== 1'b1 || mask_enable_ext !== 1'b1) begin bad++; $display("FAIL h779 got=%b%b want=11", DE_ext, mask_enable_ext); end
    wait_pos(781, 6);
    total++; if (DE_ext !== 1'b0 || mask_enable_ext !== 1'b0) begin bad++; $display("FAIL h781 got=%b%b want=00", DE_ext, mask_enable_ext); end
    wait_pos(H_TOT - 1, 6);
    tick();
    total++; if (hcnt_ext !== 11'd0 || vcnt_ext !== 11'd7) begin bad++; $display("FAIL hwrap got=%0d/%0d want=0/7", hcnt_ext, vcnt_ext); end
  endtask

  task automatic test_vrep();
    wait_pos(20, 7);
    total++; if (vctr_ext !== 3'd1 || vcnt_ext_lbuf !== 6'd0) begin bad++; $display("FAIL v7 got=%0d/%0d want=1/0", vctr_ext, vcnt_ext_lbuf); end
    wait_pos(20, 8);
    total++; if (vctr_ext !== 3'd0 || vcnt_ext_lbuf !== 6'd1) begin bad++; $display("FAIL v8 got=%0d/%0d want=0/1", vctr_ext, vcnt_ext_lbuf); end
    wait_pos(20, 9);
    total++; if (vctr_ext !== 3'd1 || vcnt_ext_lbuf !== 6'd1) begin bad++; $display("FAIL v9 got=%0d/%0d want=1/1", vctr_ext, vcnt_ext_lbuf); end
    wait_pos(20, 84);
    total++; if (vctr_ext !== 3'd0 || vcnt_ext_lbuf !== 6'd39) begin bad++; $display("FAIL v84 got=%0d/%0d want=0/39", vctr_ext, vcnt_ext_lbuf); end
    wait_pos(20, 85);
    total++; if (vctr_ext !== 3'd1 || vcnt_ext_lbuf !== 6'd39) begin bad++; $display("FAIL v85 got=%0d/%0d want=1/39", vctr_ext, vcnt_ext_lbuf); end
    wait_pos(20, 86);
    total++; if (vctr_ext !== 3'd0 || vcnt_ext_lbuf !== 6'd0) begin bad++; $display("FAIL v86 got=%0d/%0d want=0/0", vctr_ext, vcnt_ext_lbuf); end
  endtask

  // Edge far from the lock line: vcnt is pulled back to 3, not locked.
  task automatic test_lock_correct();
    wait_pos(5, 90);
    VSYNC_in = 1'b0; ticks(8);
    VSYNC_in = 1'b1;
    total++; if (vcnt_ext !== 11'd90) begin bad++; $display("FAIL corr_early got=%0d want=90", vcnt_ext); end
    wait_pos(H_TOT - 1, 90);
    tick();
    total++; if (vcnt_ext !== 11'd3 || locked !== 1'b0) begin bad++; $display("FAIL corr_jump got=%0d/%b want=3/0", vcnt_ext, locked); end
    total++; if (vctr_ext !== 3'd0 || vcnt_ext_lbuf !== 6'd0) begin bad++; $display("FAIL corr_vrep got=%0d/%0d want=0/0", vctr_ext, vcnt_ext_lbuf); end
    wait_pos(H_TOT - 1, 3);
    tick();
    total++; if (vcnt_ext !== 11'd4) begin bad++; $display("FAIL corr_next got=%0d want=4", vcnt_ext); end
  endtask

  task automatic test_reset_midframe();
    wait_pos(300, 4);
    #2 reset_n = 1'b0;
    #1;
    total++; if (hcnt_ext !== 11'd0 || vcnt_ext !== 11'd0 || HSYNC_ext !== 1'b1) begin bad++; $display("FAIL mid_rst got=%0d/%0d/%b want=0/0/1", hcnt_ext, vcnt_ext, HSYNC_ext); end
    ticks(2);
    reset_n = 1'b1;
    tick();
    total++; if (hcnt_ext !== 11'd1 || vcnt_ext !== 11'd0 || locked !== 1'b0) begin bad++; $display("FAIL mid_restart got=%0d/%0d/%b want=1/0/0", hcnt_ext, vcnt_ext, locked); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_lock_double();
    test_lock_disable();
    test_hrep();
    test_vrep();
    test_lock_correct();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
